// File: rtl/bin_pkg.sv
// Shared constants and types for the binary 7x7 window feeder.
package bin_pkg;

    localparam int K  = 7;
    localparam int KK = K * K;

    typedef logic [KK-1:0] bin_win_t;

    localparam int          W_CNT_W   = 6;
    localparam logic [5:0]  W_CNT_MAX = 6'd49;

    // Saturating increment of the weight load count.
    function automatic logic [W_CNT_W-1:0] w_cnt_inc(input logic [W_CNT_W-1:0] cnt);
        if (cnt == W_CNT_MAX) begin
            w_cnt_inc = cnt;
        end else begin
            w_cnt_inc = cnt + 6'd1;
        end
    endfunction

endpackage

// File: rtl/bin_line_buf.sv
// One image row of 1-bit delay: dout is the pixel accepted DEPTH enables ago.
module bin_line_buf #(
    parameter int DEPTH = 28
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Next shift-register contents; only advances on an accepted pixel.
    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = {sr_q[DEPTH-2:0], din};
        end else begin
            sr_d = sr_q;
        end
    end

    // Storage is intentionally not reset; stale rows are gated out upstream.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/bin_window_feeder.sv
// Builds 7x7 stride-1 windows from a 1-bpp raster stream and loads a serial 49-bit weight.
// Optional macro BIN_WIN_POS_EN adds win_row/win_col (top-left of the presented window).
module bin_window_feeder
    import bin_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          w_bit,
    input  logic          w_bit_valid,
    input  logic          w_clr,
    output logic          w_ready,
    output logic [KK-1:0] w,
    output logic [KK-1:0] img,
    output logic          win_valid,
    input  logic          win_ready,
`ifdef BIN_WIN_POS_EN
    output logic [7:0]    win_row,
    output logic [7:0]    win_col,
`endif
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [K-1:0][K-1:0]   win_q, win_d;
    bin_win_t              img_q, img_d;
    logic                  win_valid_q, win_valid_d;
    logic                  frame_done_q, frame_done_d;
    bin_win_t              w_q, w_d;
    logic [W_CNT_W-1:0]    w_cnt_q, w_cnt_d;
    logic                  w_ready_q, w_ready_d;
    logic                  accept_s, emit_s;
    logic [K-1:0]          lb_chain_s;

    assign pix_ready  = !win_valid_q || win_ready;
    assign accept_s   = pix_valid && pix_ready;
    assign lb_chain_s[0] = pix_in;

    // lb_chain_s[i] is the pixel i rows above the incoming one, same column.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        bin_line_buf #(.DEPTH(IMG_W)) u_lb (
            .clk  (clk),
            .en   (accept_s),
            .din  (lb_chain_s[i]),
            .dout (lb_chain_s[i+1])
        );
    end

    // Raster position, window shift, emission and hold logic.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        emit_s       = 1'b0;
        frame_done_d = 1'b0;
        if (accept_s) begin
            for (int r = 0; r < K; r++) begin
                win_d[r] = {lb_chain_s[K-1-r], win_q[r][K-1:1]};
            end
            emit_s       = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + {{(RW-1){1'b0}}, 1'b1};
                end
            end else begin
                col_d = col_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            win_d = win_q;
        end

        // Packed row-major: win_q[r][c] lands at img[7*r+c].
        if (emit_s) begin
            win_valid_d = 1'b1;
            img_d       = bin_win_t'(win_d);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
            img_d       = img_q;
        end else begin
            win_valid_d = win_valid_q;
            img_d       = img_q;
        end
    end

    // Serial weight shift with a saturating load count.
    always_comb begin
        w_d     = w_q;
        w_cnt_d = w_cnt_q;
        if (w_bit_valid) begin
            w_d = {w_q[KK-2:0], w_bit};
        end else begin
            w_d = w_q;
        end
        if (w_clr) begin
            w_cnt_d = w_bit_valid ? 6'd1 : 6'd0;
        end else if (w_bit_valid) begin
            w_cnt_d = w_cnt_inc(w_cnt_q);
        end else begin
            w_cnt_d = w_cnt_q;
        end
        w_ready_d = (w_cnt_d == W_CNT_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            img_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            w_q          <= '0;
            w_cnt_q      <= '0;
            w_ready_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            img_q        <= img_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            w_q          <= w_d;
            w_cnt_q      <= w_cnt_d;
            w_ready_q    <= w_ready_d;
        end
    end

`ifdef BIN_WIN_POS_EN
    logic [7:0] win_row_q, win_row_d;
    logic [7:0] win_col_q, win_col_d;

    // Top-left coordinate travels with img.
    always_comb begin
        if (emit_s) begin
            win_row_d = 8'(row_q) - 8'd6;
            win_col_d = 8'(col_q) - 8'd6;
        end else begin
            win_row_d = win_row_q;
            win_col_d = win_col_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_q <= 8'd0;
            win_col_q <= 8'd0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

    assign img        = img_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign w          = w_q;
    assign w_ready    = w_ready_q;

endmodule

// File: tb/tb_bin_window_feeder.sv
// Scoreboard bench for bin_window_feeder on an 8x8 image.
module tb_bin_window_feeder;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        logic [48:0] img;
        logic [7:0]  r;
        logic [7:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_in = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        w_bit = 1'b0;
    logic        w_bit_valid = 1'b0;
    logic        w_clr = 1'b0;
    logic        w_ready;
    logic [48:0] w;
    logic [48:0] img;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic        frame_done;
`ifdef BIN_WIN_POS_EN
    logic [7:0]  win_row;
    logic [7:0]  win_col;
`endif

    always #5 clk = ~clk;

    bin_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .w_bit       (w_bit),
        .w_bit_valid (w_bit_valid),
        .w_clr       (w_clr),
        .w_ready     (w_ready),
        .w           (w),
        .img         (img),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
`ifdef BIN_WIN_POS_EN
        .win_row     (win_row),
        .win_col     (win_col),
`endif
        .frame_done  (frame_done)
    );

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [48:0] got_q[$];
    logic        pm [0:H-1][0:W-1];
    int          mr = 0;
    int          mc = 0;
    logic        fd_exp = 1'b0;
    int          fd_seen = 0;
    logic [48:0] w_exp = '0;
    int          wcnt = 0;
    int          wins = 0;

    task automatic check_val(input string tag, input logic [48:0] got, input logic [48:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic pixval(input int mode, input int r, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (r == 6 && c == 6);
        return 1'($urandom % 2);
    endfunction

    task automatic step(input logic p, input logic v, input logic rdy,
                        input logic wb, input logic wv, input logic wc, output logic acc);
        logic        ev;
        exp_t        e;
        @(posedge clk);
        #1;
        pix_in = p; pix_valid = v; win_ready = rdy;
        w_bit = wb; w_bit_valid = wv; w_clr = wc;
        @(negedge clk);
        ev = (sb_q.size() > 0);
        check_val("win_valid", 49'(win_valid), 49'(ev));
        check_val("pix_ready", 49'(pix_ready), 49'(!ev || rdy));
        check_val("frame_done", 49'(frame_done), 49'(fd_exp));
        check_val("w", w, w_exp);
        check_val("w_ready", 49'(w_ready), 49'(wcnt == 49));
        if (frame_done) fd_seen++;
        if (ev) begin
            check_val("img", img, sb_q[0].img);
`ifdef BIN_WIN_POS_EN
            check_val("win_row", 49'(win_row), 49'(sb_q[0].r));
            check_val("win_col", 49'(win_col), 49'(sb_q[0].c));
`endif
            if (rdy) begin
                got_q.push_back(img);
                void'(sb_q.pop_front());
                wins++;
            end
        end
        acc = v && (!ev || rdy);
        fd_exp = 1'b0;
        if (acc) begin
            pm[mr][mc] = p;
            if (mr >= 6 && mc >= 6) begin
                e.img = '0;
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 7; j++)
                        e.img[7*i+j] = pm[mr-6+i][mc-6+j];
                e.r = 8'(mr - 6);
                e.c = 8'(mc - 6);
                sb_q.push_back(e);
            end
            if (mr == H-1 && mc == W-1) fd_exp = 1'b1;
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        if (wv) w_exp = {w_exp[47:0], wb};
        if (wc) wcnt = wv ? 1 : 0;
        else if (wv && wcnt < 49) wcnt = wcnt + 1;
    endtask

    task automatic run_frame(input int mode, input int stall, input int npix);
        int   n = 0;
        int   cyc = 0;
        int   st = stall;
        logic rdy, acc;
        wins = 0;
        got_q.delete();
        while (n < npix && cyc < 400) begin
            rdy = 1'b1;
            if (st > 0 && sb_q.size() > 0) begin
                rdy = 1'b0;
                st--;
            end
            step(pixval(mode, mr, mc), 1'b1, rdy, 1'b0, 1'b0, 1'b0, acc);
            if (acc) n++;
            cyc++;
        end
        check_val("frame_budget", 49'(n), 49'(npix));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic reset_model();
        sb_q.delete();
        mr = 0; mc = 0; fd_exp = 1'b0; w_exp = '0; wcnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_win_valid"}, 49'(win_valid), 49'd0);
        check_val({tag, "_img"}, img, 49'd0);
        check_val({tag, "_w"}, w, 49'd0);
        check_val({tag, "_w_ready"}, 49'(w_ready), 49'd0);
        check_val({tag, "_frame_done"}, 49'(frame_done), 49'd0);
        check_val({tag, "_pix_ready"}, 49'(pix_ready), 49'd1);
    endtask

    initial begin
        logic        acc;
        logic [48:0] one;
        one = 49'd1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones frame.
        fd_seen = 0;
        run_frame(0, 0, 64);
        check_val("ones_count", 49'(wins), 49'd4);
        check_val("ones_fd_pulses", 49'(fd_seen), 49'd1);
        for (int k = 0; k < 4; k++) check_val("ones_img", got_q[k], 49'h1FFFFFFFFFFFF);

        // Single set pixel at (6,6).
        run_frame(1, 0, 64);
        check_val("single_count", 49'(wins), 49'd4);
        check_val("single_w0", got_q[0], one << 48);
        check_val("single_w1", got_q[1], one << 47);
        check_val("single_w2", got_q[2], one << 41);
        check_val("single_w3", got_q[3], one << 40);

        // Consumer stall of 5 cycles on the first window.
        run_frame(2, 5, 64);
        check_val("stall_count", 49'(wins), 49'd4);

        // Alternating weight load, then clear, then clear+shift together.
        for (int i = 0; i < 49; i++) step(1'b0, 1'b0, 1'b1, 1'((i % 2) == 0), 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check_val("w_alt", w, 49'h1_5555_5555_5555);
        check_val("w_alt_ready", 49'(w_ready), 49'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check_val("w_clr_ready", 49'(w_ready), 49'd0);
        check_val("w_clr_keep", w, 49'h1_5555_5555_5555);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        for (int i = 0; i < 49; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);

        // Abort mid-frame with async reset.
        run_frame(2, 0, 30);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pix_valid = 1'b0; w_bit_valid = 1'b0; w_clr = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(2, 0, 64);
        check_val("post_rst_count", 49'(wins), 49'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_window_feeder.md
Name: bin_window_feeder

Overview:
- Streaming front end for the binary XNOR/popcount multiplier.
- Accepts a serial 1-bit-per-pixel binarized image, row-major, and builds 7x7 stride-1 windows using six line buffers plus a 7x7 shift window.
- Presents each window as a 49-bit vector, together with a serially loaded 49-bit weight vector, over a valid/ready handshake.
- Sits between the image source and the multiplier's img/w inputs.

Parameters:
- IMG_W, 28, image width in pixels (>=7)
- IMG_H, 28, image height in pixels (>=7)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pix_in  in  1  binary pixel
- pix_valid  in  1  pixel strobe
- pix_ready  out  1  feeder can accept a pixel
- w_bit  in  1  serial weight bit
- w_bit_valid  in  1  weight shift strobe
- w_clr  in  1  restart weight load count
- w_ready  out  1  49 weight bits loaded
- w  out  49  weight vector
- img  out  49  window vector
- win_valid  out  1  window available
- win_ready  in  1  consumer takes window
- frame_done  out  1  one-cycle pulse on the last pixel of a frame

Behaviour:
- Reset values: pix_ready=1, win_valid=0, img=0, w=0, w_ready=0, frame_done=0; row/col counters=0, weight count=0. Line buffer contents are don't-care and are not cleared.
- Pixel acceptance:
  - A pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !win_valid || win_ready (combinational; no skid buffer).
- On accept at (row,col):
  - Shift the pixel into the row-col window and line buffers.
  - col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1): row and col wrap to 0 and frame_done pulses on the following cycle.
- Window emission:
  - Condition: the accepted pixel has row>=6 && col>=6.
  - Next cycle: win_valid=1 and img holds the window whose bottom-right pixel is that pixel. Latency is 1 cycle.
  - Packing: img[7*r+c], with r,c in 0..6 relative to the window's top-left. r=0 is the oldest row, c=0 is the leftmost column.
- Window hold and release:
  - win_valid and img hold stable until win_ready.
  - win_ready with no new window-producing accept: win_valid drops.
  - win_ready together with a window-producing accept in the same cycle: win_valid stays 1 and img updates.
- Frame boundaries:
  - Windows never straddle a row wrap; columns 0..5 of each row produce no window.
  - Stale line-buffer data from the previous frame is never emitted, because windows are gated by row>=6.
- Weight loading:
  - Each w_bit_valid does w <= {w[47:0], w_bit}.
  - The count increments and saturates at 49. w_ready = (count==49).
  - Further shifts after saturation keep shifting, and w_ready stays 1.
  - w_clr clears the count, so w_ready=0 next cycle; w is unchanged. If w_clr and w_bit_valid occur together, the shift happens and the count becomes 1.
  - Weight loading is independent of the pixel stream.
- Total frame output: (IMG_W-6)*(IMG_H-6) windows.
- Asynchronous reset mid-frame aborts the frame. Any held window is dropped, and the next accepted pixel is treated as (0,0).

Optional Feature:
- Macro: BIN_WIN_POS_EN.
- Defined: adds outputs win_row[7:0] and win_col[7:0], the top-left coordinate of the presented window. Both are registered with img and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bin_pkg:
  - K=7, KK=49.
  - typedef logic [KK-1:0] bin_win_t.
  - localparam for the saturating weight count limit.
- Sub-module bin_line_buf: one IMG_W-deep, 1-bit delay line with shift enable. Instantiated 6 times in a chain.

Test Plan:
- IMG_W=IMG_H=8, all-ones stream, win_ready=1 -> exactly 4 windows, each img=49'h1FFFFFFFFFFFF; frame_done pulses once, after pixel 63.
- 8x8 image with a single 1 at (6,6), win_ready=1:
  - windows in order have img = 1<<48, 1<<47, 1<<41, 1<<40.
  - every other bit is 0.
- win_ready held low for 5 cycles while the first window is valid:
  - img and win_valid stay stable and pix_ready=0.
  - no pixels are accepted.
  - after release, the remaining 3 windows arrive in order with correct contents.
- Weight load of 49 bits (alternating 1,0,...) -> w=49'h15555_5555_5555 and w_ready=1 after the 49th shift; then w_clr -> w_ready=0 and w unchanged.
- rst_n asserted after 30 accepted pixels of frame 1:
  - outputs return to reset values.
  - a full following 8x8 frame yields exactly 4 correct windows.
- With BIN_WIN_POS_EN defined, 8x8 frame -> (win_row,win_col) = (0,0), (0,1), (1,0), (1,1).
